// File: rtl/banked_wram_hram_if.sv
// Simple byte-wide memory bus shared by the CPU/MMU and HRAM ports.
// The slave drives rdata combinationally from addr/read_en.
interface Bus_if;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        read_en;
  logic        write_en;

  modport Slave_side (
    input  addr,
    input  wdata,
    input  read_en,
    input  write_en,
    output rdata
  );

  modport Master_side (
    output addr,
    output wdata,
    output read_en,
    output write_en,
    input  rdata
  );
endinterface

// File: rtl/banked_wram_hram.sv
// CGB-style banked WRAM plus HRAM with SVBK bank select, an OAM DMA read port
// and a power-on clear sequencer that fills both arrays after reset.
module banked_wram_hram #(
  parameter int       NUM_BANKS      = 8,
  parameter int       HRAM_LEN       = 127,
  parameter bit       CLEAR_ON_RESET = 1'b1,
  parameter bit [7:0] FILL_VALUE     = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  Bus_if.Slave_side   bus,
  Bus_if.Slave_side   hram_bus,
  input  logic [15:0] dma_addr,
  output logic [7:0]  dma_rdata,
  output logic        busy,
  output logic [2:0]  svbk
);

  localparam int BB         = $clog2(NUM_BANKS);
  localparam int WRAM_AW    = BB + 12;
  localparam int WRAM_DEPTH = NUM_BANKS * 4096;
  localparam int HRAM_AW    = (HRAM_LEN > 1) ? $clog2(HRAM_LEN) : 1;
  localparam bit HAS_SVBK   = (NUM_BANKS > 2);

  localparam logic [15:0]        SVBK_ADDR = 16'hFF70;
  localparam logic [15:0]        HRAM_BASE = 16'hFF80;
  localparam logic [WRAM_AW-1:0] WRAM_LAST = WRAM_AW'(WRAM_DEPTH - 1);
  localparam logic [HRAM_AW-1:0] HRAM_LAST = HRAM_AW'(HRAM_LEN - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WRAM_AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [HRAM_AW-1:0] hram_cnt_q, hram_cnt_d;
  logic [BB-1:0]      svbk_q, svbk_d;

  // NOTE: the storage arrays have no reset; post-reset contents are defined
  // only by the clear sequencer, which keeps them as plain RAM macros.
  logic [7:0] wram_mem [WRAM_DEPTH];
  logic [7:0] hram_mem [HRAM_LEN];

  function automatic logic wram_hit(input logic [15:0] a);
    return (a >= 16'hC000) && (a <= 16'hFDFF);
  endfunction

  // Echo space keeps addr[12] as the bank-0 / switchable-bank selector.
  function automatic logic [WRAM_AW-1:0] wram_index(input logic [15:0]   a,
                                                    input logic [BB-1:0] bank);
    return a[12] ? {bank, a[11:0]} : {BB'(0), a[11:0]};
  endfunction

  logic [BB-1:0]      eff_bank;
  logic [7:0]         svbk_rd;
  logic               bus_wram_sel;
  logic               bus_svbk_sel;
  logic [WRAM_AW-1:0] bus_idx;
  logic               dma_wram_sel;
  logic [WRAM_AW-1:0] dma_idx;
  logic               hram_sel;
  logic [HRAM_AW-1:0] hram_idx;

  assign busy = (state_q == ST_CLEAR);
  assign svbk = 3'(svbk_q);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    eff_bank = BB'(1);
    if (HAS_SVBK && (svbk_q != '0)) eff_bank = svbk_q;
  end

  assign svbk_rd      = HAS_SVBK ? ((8'hFF << BB) | 8'(svbk_q)) : 8'hFF;
  assign bus_wram_sel = wram_hit(bus.addr);
  assign bus_svbk_sel = (bus.addr == SVBK_ADDR);
  assign bus_idx      = wram_index(bus.addr, eff_bank);
  assign dma_wram_sel = wram_hit(dma_addr);
  assign dma_idx      = wram_index(dma_addr, eff_bank);
  assign hram_sel     = (hram_bus.addr >= HRAM_BASE) &&
                        (32'(hram_bus.addr) < 32'(HRAM_BASE) + 32'(HRAM_LEN));
  assign hram_idx     = HRAM_AW'(hram_bus.addr - HRAM_BASE);

  always_comb begin
    bus.rdata = 8'hFF;
    if (!busy && bus.read_en) begin
      if (bus_wram_sel)      bus.rdata = wram_mem[bus_idx];
      else if (bus_svbk_sel) bus.rdata = svbk_rd;
    end
  end

  always_comb begin
    hram_bus.rdata = 8'hFF;
    if (!busy && hram_bus.read_en && hram_sel) hram_bus.rdata = hram_mem[hram_idx];
  end

  always_comb begin
    dma_rdata = 8'hFF;
    if (!busy && dma_wram_sel) dma_rdata = wram_mem[dma_idx];
  end

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    hram_cnt_d = hram_cnt_q;
    svbk_d     = svbk_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (hram_cnt_q != HRAM_LAST) hram_cnt_d = hram_cnt_q + 1'b1;
      if (clr_cnt_q == WRAM_LAST)  state_d    = ST_IDLE;
    end else if (HAS_SVBK && bus.write_en && bus_svbk_sel) begin
      svbk_d = bus.wdata[BB-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_cnt_q  <= '0;
      hram_cnt_q <= '0;
      svbk_q     <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      hram_cnt_q <= hram_cnt_d;
      svbk_q     <= svbk_d;
    end
  end

  // One write port per array: the clear sequencer owns it while busy.
  logic               wram_we;
  logic [WRAM_AW-1:0] wram_waddr;
  logic [7:0]         wram_wdata;
  logic               hram_we;
  logic [HRAM_AW-1:0] hram_waddr;
  logic [7:0]         hram_wdata;

  always_comb begin
    wram_we    = 1'b0;
    wram_waddr = bus_idx;
    wram_wdata = bus.wdata;
    if (busy) begin
      wram_we    = 1'b1;
      wram_waddr = clr_cnt_q;
      wram_wdata = FILL_VALUE;
    end else if (bus.write_en && bus_wram_sel) begin
      wram_we = 1'b1;
    end
  end

  always_comb begin
    hram_we    = 1'b0;
    hram_waddr = hram_idx;
    hram_wdata = hram_bus.wdata;
    if (busy) begin
      hram_we    = 1'b1;
      hram_waddr = hram_cnt_q;
      hram_wdata = FILL_VALUE;
    end else if (hram_bus.write_en && hram_sel) begin
      hram_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wram_we) wram_mem[wram_waddr] <= wram_wdata;
  end

  always_ff @(posedge clk) begin
    if (hram_we) hram_mem[hram_waddr] <= hram_wdata;
  end

endmodule

// File: tb/tb_banked_wram_hram.sv
// Directed bench for banked_wram_hram: default config, DMG config with a
// non-zero fill, and a config with the clear sequencer disabled.
module tb_banked_wram_hram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a = 1'b1, reset_b = 1'b1, reset_c = 1'b1;
  logic [15:0] dma_addr_a = 16'h0000, dma_addr_b = 16'h0000, dma_addr_c = 16'h0000;
  logic [7:0]  dma_rdata_a, dma_rdata_b, dma_rdata_c;
  logic        busy_a, busy_b, busy_c;
  logic [2:0]  svbk_a, svbk_b, svbk_c;

  Bus_if bus_a();
  Bus_if hbus_a();
  Bus_if bus_b();
  Bus_if hbus_b();
  Bus_if bus_c();
  Bus_if hbus_c();

  banked_wram_hram u_def (
    .clk(clk), .reset(reset_a), .bus(bus_a), .hram_bus(hbus_a),
    .dma_addr(dma_addr_a), .dma_rdata(dma_rdata_a), .busy(busy_a), .svbk(svbk_a)
  );

  banked_wram_hram #(.NUM_BANKS(2), .FILL_VALUE(8'hEE)) u_dmg (
    .clk(clk), .reset(reset_b), .bus(bus_b), .hram_bus(hbus_b),
    .dma_addr(dma_addr_b), .dma_rdata(dma_rdata_b), .busy(busy_b), .svbk(svbk_b)
  );

  banked_wram_hram #(.CLEAR_ON_RESET(1'b0)) u_nc (
    .clk(clk), .reset(reset_c), .bus(bus_c), .hram_bus(hbus_c),
    .dma_addr(dma_addr_c), .dma_rdata(dma_rdata_c), .busy(busy_c), .svbk(svbk_c)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic a_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_a.addr = a; bus_a.wdata = d; bus_a.read_en = 1'b0; bus_a.write_en = 1'b1;
    @(negedge clk);
    bus_a.write_en = 1'b0;
  endtask

  task automatic a_read(input string tag, input logic [15:0] a, input logic [7:0] exp);
    @(negedge clk);
    bus_a.addr = a; bus_a.read_en = 1'b1;
    #1 check(tag, bus_a.rdata, exp);
    bus_a.read_en = 1'b0;
  endtask

  task automatic h_read(input string tag, input logic [15:0] a, input logic [7:0] exp);
    @(negedge clk);
    hbus_a.addr = a; hbus_a.read_en = 1'b1;
    #1 check(tag, hbus_a.rdata, exp);
    hbus_a.read_en = 1'b0;
  endtask

  task automatic b_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_b.addr = a; bus_b.wdata = d; bus_b.read_en = 1'b0; bus_b.write_en = 1'b1;
    @(negedge clk);
    bus_b.write_en = 1'b0;
  endtask

  task automatic b_read(input string tag, input logic [15:0] a, input logic [7:0] exp);
    @(negedge clk);
    bus_b.addr = a; bus_b.read_en = 1'b1;
    #1 check(tag, bus_b.rdata, exp);
    bus_b.read_en = 1'b0;
  endtask

  initial begin
    bus_a.addr = '0;  bus_a.wdata = '0;  bus_a.read_en = 0;  bus_a.write_en = 0;
    hbus_a.addr = '0; hbus_a.wdata = '0; hbus_a.read_en = 0; hbus_a.write_en = 0;
    bus_b.addr = '0;  bus_b.wdata = '0;  bus_b.read_en = 0;  bus_b.write_en = 0;
    hbus_b.addr = '0; hbus_b.wdata = '0; hbus_b.read_en = 0; hbus_b.write_en = 0;
    bus_c.addr = '0;  bus_c.wdata = '0;  bus_c.read_en = 0;  bus_c.write_en = 0;
    hbus_c.addr = '0; hbus_c.wdata = '0; hbus_c.read_en = 0; hbus_c.write_en = 0;

    // ---------------- default configuration ----------------
    @(negedge clk);
    #1 check("rst_busy", busy_a, 1);
    check("rst_svbk", svbk_a, 0);

    // First clear gets aborted by a reset pulse at cycle 1000.
    @(negedge clk) reset_a = 1'b0;
    repeat (1000) @(posedge clk);
    #1 check("busy_pre_pulse", busy_a, 1);
    @(negedge clk) reset_a = 1'b1;
    #1 check("busy_in_pulse", busy_a, 1);
    @(negedge clk) reset_a = 1'b0;

    // Second release: busy must fall exactly on edge 32768.
    repeat (32000) @(posedge clk);
    @(negedge clk);
    bus_a.addr = 16'hC000; bus_a.read_en = 1'b1;
    dma_addr_a = 16'hC000; hbus_a.addr = 16'hFF80; hbus_a.read_en = 1'b1;
    #1 check("busy_rd_c000", bus_a.rdata, 8'hFF);
    check("busy_dma", dma_rdata_a, 8'hFF);
    check("busy_hram", hbus_a.rdata, 8'hFF);
    bus_a.read_en = 1'b0; hbus_a.read_en = 1'b0;
    bus_a.wdata = 8'h55; bus_a.write_en = 1'b1;
    @(posedge clk);
    @(negedge clk) bus_a.write_en = 1'b0;
    repeat (766) @(posedge clk);
    #1 check("busy_edge32767", busy_a, 1);
    @(posedge clk);
    #1 check("busy_edge32768", busy_a, 0);

    a_read("clr_c000", 16'hC000, 8'h00);
    a_read("clr_dfff", 16'hDFFF, 8'h00);
    h_read("clr_ff80", 16'hFF80, 8'h00);
    h_read("clr_fffe", 16'hFFFE, 8'h00);
    h_read("hram_ffff_oob", 16'hFFFF, 8'hFF);

    // Banking
    a_write(16'hFF70, 8'h00); a_write(16'hD123, 8'h11);
    a_write(16'hFF70, 8'h02); a_write(16'hD123, 8'h22);
    a_write(16'hFF70, 8'h07); a_write(16'hD123, 8'h33);
    a_write(16'hFF70, 8'h01); a_read("bank1_d123", 16'hD123, 8'h11);
    a_write(16'hFF70, 8'h02); a_read("bank2_d123", 16'hD123, 8'h22);
    a_read("svbk_rd_2", 16'hFF70, 8'hFA);
    check("svbk_port_2", svbk_a, 3'd2);
    a_write(16'hFF70, 8'h07); a_read("bank7_d123", 16'hD123, 8'h33);
    a_read("svbk_rd_7", 16'hFF70, 8'hFF);

    // Echo
    a_write(16'hE010, 8'hA5); a_read("echo_c010", 16'hC010, 8'hA5);
    a_write(16'hFF70, 8'h03); a_write(16'hF020, 8'h5A);
    a_read("echo_d020", 16'hD020, 8'h5A);
    a_read("bank3_d123", 16'hD123, 8'h00);

    // DMA alongside a bus read of the same byte
    @(negedge clk);
    bus_a.addr = 16'hC010; bus_a.read_en = 1'b1; dma_addr_a = 16'hC010;
    #1 check("same_rd_bus", bus_a.rdata, 8'hA5);
    check("same_rd_dma", dma_rdata_a, 8'hA5);
    bus_a.read_en = 1'b0;
    dma_addr_a = 16'h8000;
    #1 check("dma_8000", dma_rdata_a, 8'hFF);

    // DMA during an SVBK write sees the old bank, then the new one.
    @(negedge clk);
    dma_addr_a = 16'hD020;
    bus_a.addr = 16'hFF70; bus_a.wdata = 8'h07; bus_a.write_en = 1'b1;
    #1 check("dma_old_bank", dma_rdata_a, 8'h5A);
    @(posedge clk);
    #1 check("dma_new_bank", dma_rdata_a, 8'h00);
    @(negedge clk) bus_a.write_en = 1'b0;

    a_read("unsel_8000", 16'h8000, 8'hFF);
    @(negedge clk);
    bus_a.addr = 16'hC010; bus_a.read_en = 1'b0;
    #1 check("rd_en_low", bus_a.rdata, 8'hFF);

    // Simultaneous bus and hram_bus writes both commit.
    @(negedge clk);
    bus_a.addr = 16'hC020; bus_a.wdata = 8'h77; bus_a.write_en = 1'b1;
    hbus_a.addr = 16'hFFFE; hbus_a.wdata = 8'h3C; hbus_a.write_en = 1'b1;
    @(negedge clk);
    bus_a.write_en = 1'b0; hbus_a.write_en = 1'b0;
    a_read("dual_wr_bus", 16'hC020, 8'h77);
    h_read("dual_wr_hram", 16'hFFFE, 8'h3C);

    // ---------------- DMG configuration, fill 0xEE ----------------
    @(negedge clk) reset_b = 1'b0;
    repeat (8191) @(posedge clk);
    #1 check("dmg_busy_8191", busy_b, 1);
    @(posedge clk);
    #1 check("dmg_busy_8192", busy_b, 0);
    b_read("dmg_d000", 16'hD000, 8'hEE);
    b_read("dmg_c000", 16'hC000, 8'hEE);
    @(negedge clk);
    hbus_b.addr = 16'hFF80; hbus_b.read_en = 1'b1;
    #1 check("dmg_ff80", hbus_b.rdata, 8'hEE);
    hbus_b.read_en = 1'b0;
    b_write(16'hFF70, 8'h03);
    b_read("dmg_svbk_rd", 16'hFF70, 8'hFF);
    check("dmg_svbk_port", svbk_b, 0);
    b_write(16'hD000, 8'h44);
    b_read("dmg_d000_wr", 16'hD000, 8'h44);
    b_read("dmg_echo_f000", 16'hF000, 8'h44);

    // ---------------- clear disabled ----------------
    @(negedge clk);
    #1 check("nc_busy_in_rst", busy_c, 0);
    @(negedge clk) reset_c = 1'b0;
    #1 check("nc_busy_rel", busy_c, 0);
    @(negedge clk);
    bus_c.addr = 16'hC000; bus_c.wdata = 8'h12; bus_c.write_en = 1'b1;
    @(negedge clk);
    bus_c.write_en = 1'b0; bus_c.read_en = 1'b1;
    #1 check("nc_rd_c000", bus_c.rdata, 8'h12);
    bus_c.read_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/banked_wram_hram.md
# banked_wram_hram

Memory block that holds CGB-style banked work RAM (WRAM) and high RAM (HRAM), with a power-on clear sequencer. The number of WRAM banks is a parameter, and bank selection goes through the SVBK register at 0xFF70. It sits behind the MMU on the CPU bus, with a dedicated HRAM bus and a third read-only port for OAM DMA source fetches. It supersedes the fixed 8 KiB WRAM / 127 B HRAM store: banking, a DMA read channel and deterministic post-reset contents are new.

## Interface
Parameters:
- NUM_BANKS, default 8: number of 4 KiB WRAM banks. Power of two, 2..8. A value of 2 gives DMG mode with no SVBK register.
- HRAM_LEN, default 127: HRAM size in bytes, mapped from 0xFF80.
- CLEAR_ON_RESET, default 1: when 1, all WRAM and HRAM is filled with FILL_VALUE after reset.
- FILL_VALUE, default 8'h00: byte written by the clear sequencer.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-high.
- bus, Bus_if.Slave_side (addr 16, wdata 8, rdata 8, read_en, write_en): CPU/MMU port for WRAM, echo and SVBK.
- hram_bus, Bus_if.Slave_side: HRAM port.
- dma_addr, input, 16: OAM DMA source address.
- dma_rdata, output, 8: DMA read data.
- busy, output, 1: the clear sequencer is running.
- svbk, output, 3: current raw SVBK value, for debug and savestate.

## Operation
- Address decode on bus:
  - 0xC000–0xCFFF maps to bank 0.
  - 0xD000–0xDFFF maps to bank eff_bank.
  - 0xE000–0xFDFF mirrors 0xC000–0xDDFF, using the same eff_bank.
  - 0xFF70 maps to SVBK.
- Bank bit count BB = $clog2(NUM_BANKS). The SVBK register stores BB bits.
- eff_bank = (svbk[BB-1:0] == 0) ? 1 : svbk[BB-1:0].
- Physical WRAM index = {bank, addr[11:0]}. The array has NUM_BANKS*4096 bytes.
- SVBK write stores wdata[BB-1:0]. SVBK read returns the stored bits with all upper bits set to 1 (e.g. NUM_BANKS=8 gives {5'b11111, svbk}).
- When NUM_BANKS=2, SVBK is not implemented: writes are ignored, reads return 0xFF, and eff_bank is always 1.
- hram_bus decodes 0xFF80 to 0xFF80+HRAM_LEN-1. Index = addr − 0xFF80.
- DMA port: dma_addr is decoded like bus (WRAM and echo only, using eff_bank). Out-of-range addresses return 0xFF. It is independent of bus and may access the same byte in the same cycle.
- Unselected reads, or reads with read_en low, return 0xFF on bus and hram_bus.
- Clear state machine, states CLEAR and IDLE:
  - Reset forces CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
  - In CLEAR, one WRAM byte is written per cycle, with the counter running from 0 to NUM_BANKS*4096−1.
  - In parallel, one HRAM byte is written per cycle from 0 to HRAM_LEN−1. The HRAM counter saturates when done.
  - CLEAR moves to IDLE on the cycle after the last WRAM byte is written.
- While busy=1:
  - bus, hram_bus and DMA writes are dropped.
  - All reads return 0xFF.
  - SVBK writes are dropped.

## Timing
- Reset values: busy = CLEAR_ON_RESET, svbk = 0 (so eff_bank = 1), clear counters = 0.
- Reset does not initialise memory contents except through the clear sequencer.
- Reads are combinational: rdata and dma_rdata are valid in the same cycle as addr/read_en.
- Writes commit at posedge clk when write_en is high and the address is selected. A read of the same address in the next cycle returns the new data.
- An SVBK write takes effect at the clock edge. A D000 access in the same cycle as the SVBK write cannot occur (single bus). The first access using the new bank is the next cycle.
- A DMA read in the cycle of an SVBK write uses the old bank.
- Clear duration is NUM_BANKS*4096 cycles after reset deasserts; busy falls on the next edge. With defaults: 32768 cycles.
- Reset asserted mid-clear aborts the sequence; on release the counters restart at 0.
- A bus write and an hram_bus write in the same cycle both commit, because they target separate arrays.

## Test plan
- Defaults: release reset, wait until busy=0 (exactly 32768 cycles), read 0xC000, 0xDFFF, 0xFF80 and 0xFFFE → each returns 0x00. During busy, reading 0xC000 returns 0xFF and a write of 0x55 is lost.
- Banking: write 0x11 to D123 with SVBK=0, write 0x22 with SVBK=2, write 0x33 with SVBK=7. Read back with SVBK=1 → 0x11; SVBK=2 → 0x22; SVBK=7 → 0x33. Reading 0xFF70 after SVBK=2 returns 0xFA.
- Echo: write 0xA5 to 0xE010 → reading 0xC010 returns 0xA5. With SVBK=3, write 0x5A to 0xF020 → reading 0xD020 returns 0x5A.
- DMA: dma_addr = 0xC010 in the same cycle as a bus read of 0xC010 → both return 0xA5. dma_addr = 0x8000 → 0xFF.
- NUM_BANKS=2, FILL_VALUE=0xEE: after the 8192-cycle clear, 0xD000 reads 0xEE. An SVBK write is ignored, and 0xFF70 reads 0xFF.
- Reset pulse at cycle 1000 of the clear → busy stays high and the clear restarts, so busy falls 32768 cycles after the second release. Also hold CLEAR_ON_RESET=0 → busy=0 immediately after reset.
